// File: rtl/nic_fifo.sv
// nic_fifo: network interface controller between a processor register port
// and one router port. Two independent circular FIFOs decouple the sides:
//   inject FIFO: processor -> network (INJ_DEPTH entries)
//   eject  FIFO: network -> processor (EJ_DEPTH entries)
// Each FIFO has an occupancy count. Sticky overflow (inject) and underflow
// (eject) flags are set on illegal accesses and cleared by a status write.
//
// Ports:
//   clk           clock, rising edge
//   reset         asynchronous active-high reset, clears all state
//   addr          register select: 00 eject data, 01 eject status,
//                 10 inject data, 11 inject status
//   d_in          processor write data
//   d_out         processor read data (combinational, 0 when nicEn=0)
//   nicEn         access enable
//   nicWrEn       1 = write, 0 = read
//   net_so        inject flit valid to router
//   net_ro        router ready for the inject flit
//   net_do        inject FIFO head (0 when empty)
//   net_polarity  current router polarity (even/odd virtual channel)
//   net_si        eject flit valid from router
//   net_ri        NIC ready to accept an eject flit
//   net_di        eject flit data
//
// Status word layout: [DATA_W-1] = non-empty (eject) / full (inject),
// [DATA_W-2] = sticky error flag, [CNT_W-1:0] = entry count, rest 0.
module nic_fifo #(
  parameter int DATA_W    = 64,
  parameter int INJ_DEPTH = 4,
  parameter int EJ_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  output logic              net_so,
  input  logic              net_ro,
  output logic [DATA_W-1:0] net_do,
  input  logic              net_polarity,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [DATA_W-1:0] net_di
);

  localparam int MAX_DEPTH = (INJ_DEPTH > EJ_DEPTH) ? INJ_DEPTH : EJ_DEPTH;
  localparam int CNT_W     = $clog2(MAX_DEPTH + 1);
  localparam int INJ_AW    = $clog2(INJ_DEPTH);
  localparam int EJ_AW     = $clog2(EJ_DEPTH);

  localparam logic [CNT_W-1:0] INJ_FULL_CNT = CNT_W'(INJ_DEPTH);
  localparam logic [CNT_W-1:0] EJ_FULL_CNT  = CNT_W'(EJ_DEPTH);

  // Inject FIFO state
  logic [DATA_W-1:0] inj_mem [INJ_DEPTH];
  logic [INJ_AW-1:0] inj_head, inj_tail;
  logic [CNT_W-1:0]  inj_cnt;
  logic              ovf_flag;

  // Eject FIFO state
  logic [DATA_W-1:0] ej_mem [EJ_DEPTH];
  logic [EJ_AW-1:0]  ej_head, ej_tail;
  logic [CNT_W-1:0]  ej_cnt;
  logic              unf_flag;

  logic inj_empty, inj_full, inj_push, inj_pop;
  logic ej_empty, ej_full, ej_push, ej_pop;
  logic proc_push_req, proc_pop_req, clr_ovf, clr_unf;
  logic [DATA_W-1:0] inj_status, ej_status;

  // ---------------------------------------------------------------------------
  // Decode and handshakes. Fullness/emptiness are the pre-edge values, so a
  // push into a full inject FIFO is dropped even if the router pops in the
  // same cycle.
  // ---------------------------------------------------------------------------
  assign inj_empty = (inj_cnt == '0);
  assign inj_full  = (inj_cnt == INJ_FULL_CNT);
  assign ej_empty  = (ej_cnt == '0);
  assign ej_full   = (ej_cnt == EJ_FULL_CNT);

  assign proc_push_req = nicEn && nicWrEn  && (addr == 2'b10);
  assign proc_pop_req  = nicEn && !nicWrEn && (addr == 2'b00);
  assign clr_unf       = nicEn && nicWrEn  && (addr == 2'b01) && d_in[0];
  assign clr_ovf       = nicEn && nicWrEn  && (addr == 2'b11) && d_in[0];

  assign inj_push = proc_push_req && !inj_full;
  assign ej_pop   = proc_pop_req && !ej_empty;

  // The head is only offered when its VC bit disagrees with the router's
  // current polarity; a mismatching head blocks everything behind it.
  assign net_do  = inj_empty ? '0 : inj_mem[inj_head];
  assign net_so  = !inj_empty && (net_do[0] != net_polarity);
  assign inj_pop = net_so && net_ro;

  assign net_ri  = !ej_full;
  assign ej_push = net_si && !ej_full;

  // ---------------------------------------------------------------------------
  // Storage. Pointers wrap naturally because depths are powers of two.
  // ---------------------------------------------------------------------------
  // NOTE: the data arrays have no reset; stale entries are never visible
  // because every read path is masked by the empty flag.
  always_ff @(posedge clk) begin
    if (inj_push) inj_mem[inj_tail] <= d_in;
    if (ej_push)  ej_mem[ej_tail]   <= net_di;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inj_head <= '0;
      inj_tail <= '0;
      inj_cnt  <= '0;
    end else begin
      if (inj_push) inj_tail <= inj_tail + INJ_AW'(1);
      if (inj_pop)  inj_head <= inj_head + INJ_AW'(1);
      case ({inj_push, inj_pop})
        2'b10:   inj_cnt <= inj_cnt + CNT_W'(1);
        2'b01:   inj_cnt <= inj_cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ej_head <= '0;
      ej_tail <= '0;
      ej_cnt  <= '0;
    end else begin
      if (ej_push) ej_tail <= ej_tail + EJ_AW'(1);
      if (ej_pop)  ej_head <= ej_head + EJ_AW'(1);
      case ({ej_push, ej_pop})
        2'b10:   ej_cnt <= ej_cnt + CNT_W'(1);
        2'b01:   ej_cnt <= ej_cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Sticky error flags. Set and clear come from different addresses, so they
  // can never collide in one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_flag <= 1'b0;
      unf_flag <= 1'b0;
    end else begin
      if (proc_push_req && inj_full) ovf_flag <= 1'b1;
      else if (clr_ovf)              ovf_flag <= 1'b0;

      if (proc_pop_req && ej_empty)  unf_flag <= 1'b1;
      else if (clr_unf)              unf_flag <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Processor read path
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    ej_status               = '0;
    ej_status[DATA_W-1]     = !ej_empty;
    ej_status[DATA_W-2]     = unf_flag;
    ej_status[CNT_W-1:0]    = ej_cnt;

    inj_status              = '0;
    inj_status[DATA_W-1]    = inj_full;
    inj_status[DATA_W-2]    = ovf_flag;
    inj_status[CNT_W-1:0]   = inj_cnt;
  end

  always_comb begin
    d_out = '0;
    if (nicEn) begin
      case (addr)
        2'b00: d_out = ej_empty ? '0 : ej_mem[ej_head];
        2'b01: d_out = ej_status;
        2'b10: d_out = inj_empty ? '0 : inj_mem[inj_head];
        2'b11: d_out = inj_status;
        default: d_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_nic_fifo.sv
// Self-checking bench for nic_fifo (DATA_W=64, depths 4). A queue-based model
// tracks both FIFOs and the sticky flags; a compare process checks every
// output on each falling edge, and directed phases add literal expectations.
module tb_nic_fifo;

  localparam int DATA_W    = 64;
  localparam int INJ_DEPTH = 4;
  localparam int EJ_DEPTH  = 4;

  localparam logic [63:0] TOP_BIT = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ERR_BIT = 64'h4000_0000_0000_0000;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [1:0]        addr = '0;
  logic [DATA_W-1:0] d_in = '0;
  logic [DATA_W-1:0] d_out;
  logic              nicEn = 1'b0;
  logic              nicWrEn = 1'b0;
  logic              net_so;
  logic              net_ro = 1'b0;
  logic [DATA_W-1:0] net_do;
  logic              net_polarity = 1'b0;
  logic              net_si = 1'b0;
  logic              net_ri;
  logic [DATA_W-1:0] net_di = '0;

  nic_fifo #(
    .DATA_W(DATA_W), .INJ_DEPTH(INJ_DEPTH), .EJ_DEPTH(EJ_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_so(net_so), .net_ro(net_ro),
    .net_do(net_do), .net_polarity(net_polarity), .net_si(net_si),
    .net_ri(net_ri), .net_di(net_di)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: FIFOs as queues, flags as bits.
  // ---------------------------------------------------------------------------
  logic [63:0] inj_q[$];
  logic [63:0] ej_q[$];
  bit ovf = 1'b0;
  bit unf = 1'b0;

  function automatic logic [63:0] m_net_do();
    return (inj_q.size() != 0) ? inj_q[0] : 64'h0;
  endfunction

  function automatic logic m_net_so();
    logic [63:0] h;
    if (inj_q.size() == 0) return 1'b0;
    h = inj_q[0];
    return h[0] != net_polarity;
  endfunction

  function automatic logic m_net_ri();
    return ej_q.size() < EJ_DEPTH;
  endfunction

  function automatic logic [63:0] m_d_out();
    logic [63:0] r;
    r = 64'h0;
    if (nicEn) begin
      case (addr)
        2'd0: r = (ej_q.size() != 0) ? ej_q[0] : 64'h0;
        2'd1: r = ((ej_q.size() != 0) ? TOP_BIT : 64'h0) + (unf ? ERR_BIT : 64'h0)
                  + 64'(ej_q.size());
        2'd2: r = (inj_q.size() != 0) ? inj_q[0] : 64'h0;
        default: r = ((inj_q.size() == INJ_DEPTH) ? TOP_BIT : 64'h0) + (ovf ? ERR_BIT : 64'h0)
                  + 64'(inj_q.size());
      endcase
    end
    return r;
  endfunction

  task automatic model_step();
    int  inj_n;
    int  ej_n;
    bit  n_pop;
    inj_n = inj_q.size();
    ej_n  = ej_q.size();
    n_pop = m_net_so() && net_ro;
    if (n_pop) void'(inj_q.pop_front());
    if (nicEn && nicWrEn && addr == 2'd2) begin
      if (inj_n == INJ_DEPTH) ovf = 1'b1;
      else inj_q.push_back(d_in);
    end
    if (nicEn && !nicWrEn && addr == 2'd0) begin
      if (ej_n == 0) unf = 1'b1;
      else void'(ej_q.pop_front());
    end
    if (net_si && ej_n < EJ_DEPTH) ej_q.push_back(net_di);
    if (nicEn && nicWrEn && addr == 2'd1 && d_in[0]) unf = 1'b0;
    if (nicEn && nicWrEn && addr == 2'd3 && d_in[0]) ovf = 1'b0;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      inj_q.delete();
      ej_q.delete();
      ovf = 1'b0;
      unf = 1'b0;
    end else begin
      model_step();
    end
  end

  // Compare process: outputs checked once per cycle on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("net_do", net_do, m_net_do());
      check("net_so", 64'(net_so), 64'(m_net_so()));
      check("net_ri", 64'(net_ri), 64'(m_net_ri()));
      check("d_out", d_out, m_d_out());
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 ns after the falling edge.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    nicEn = 1'b0; nicWrEn = 1'b0; addr = 2'd0; d_in = '0;
    net_si = 1'b0; net_di = '0;
  endtask

  task automatic proc_set(input logic en, input logic wr, input logic [1:0] a, input logic [63:0] d);
    nicEn = en; nicWrEn = wr; addr = a; d_in = d;
  endtask

  // Side-effect-free status read, sampled mid-cycle.
  task automatic status_check(input string name, input logic [1:0] a, input logic [63:0] exp);
    proc_set(1'b1, 1'b0, a, '0);
    #1;
    check(name, d_out, exp);
  endtask

  logic [63:0] popped[$];
  logic [63:0] exp_list[$];

  initial begin
    // Reset
    #2 reset = 1'b1;
    chk_en = 1'b1;
    tick();
    tick();
    status_check("rst_ej_status", 2'd1, 64'h0);
    status_check("rst_inj_status", 2'd3, 64'h0);
    check("rst_net_ri", 64'(net_ri), 64'h1);
    check("rst_net_so", 64'(net_so), 64'h0);
    idle();
    tick();
    reset = 1'b0;
    tick();

    // Overflow: five pushes into a 4-deep inject FIFO with the router stalled
    net_ro = 1'b0;
    net_polarity = 1'b0;
    foreach (exp_list[i]) exp_list.delete(i);
    exp_list = '{64'h10, 64'h21, 64'h30, 64'h41, 64'h50};
    for (int i = 0; i < 5; i++) begin
      proc_set(1'b1, 1'b1, 2'd2, exp_list[i]);
      tick();
    end
    status_check("ovf_status", 2'd3, TOP_BIT | ERR_BIT | 64'd4);
    status_check("inj_head", 2'd2, 64'h10);
    idle();

    // Drain with polarity gating; head 0x10 stalls while polarity=0
    net_ro = 1'b1;
    net_polarity = 1'b0;
    #1;
    check("stall_so", 64'(net_so), 64'h0);
    check("stall_do", net_do, 64'h10);
    tick();
    popped.delete();
    for (int c = 0; c < 20 && popped.size() < 4; c++) begin
      net_polarity = ~net_polarity;
      #1;
      if (net_so && net_ro) popped.push_back(net_do);
      tick();
    end
    check("drain_cnt", 64'(popped.size()), 64'd4);
    for (int i = 0; i < 4 && i < popped.size(); i++)
      check("drain_order", popped[i], exp_list[i]);
    status_check("drained_status", 2'd3, ERR_BIT);
    proc_set(1'b1, 1'b1, 2'd3, 64'h1);
    tick();
    status_check("ovf_cleared", 2'd3, 64'h0);
    idle();
    net_ro = 1'b0;
    tick();

    // Eject fill: five router pushes, the fifth is refused
    for (int i = 0; i < 5; i++) begin
      net_si = 1'b1;
      net_di = 64'hA0 + 64'(i);
      tick();
    end
    net_si = 1'b0;
    #1;
    check("ej_full_ri", 64'(net_ri), 64'h0);
    status_check("ej_full_status", 2'd1, TOP_BIT | 64'd4);
    for (int i = 0; i < 5; i++) begin
      proc_set(1'b1, 1'b0, 2'd0, '0);
      #1;
      check("ej_read", d_out, (i < 4) ? 64'hA0 + 64'(i) : 64'h0);
      tick();
    end
    status_check("unf_status", 2'd1, ERR_BIT);
    proc_set(1'b1, 1'b1, 2'd1, 64'h1);
    tick();
    status_check("unf_cleared", 2'd1, 64'h0);
    idle();
    tick();

    // Simultaneous push/pop on eject holding 2, across pointer wrap-around
    for (int i = 0; i < 2; i++) begin
      net_si = 1'b1;
      net_di = 64'hB0 + 64'(i);
      tick();
    end
    popped.delete();
    for (int i = 0; i < 12; i++) begin
      net_si = 1'b1;
      net_di = 64'hC0 + 64'(i);
      proc_set(1'b1, 1'b0, 2'd0, '0);
      #1;
      popped.push_back(d_out);
      tick();
    end
    net_si = 1'b0;
    status_check("simul_status", 2'd1, TOP_BIT | 64'd2);
    for (int i = 0; i < 2; i++) begin
      proc_set(1'b1, 1'b0, 2'd0, '0);
      #1;
      popped.push_back(d_out);
      tick();
    end
    idle();
    check("wrap_cnt", 64'(popped.size()), 64'd14);
    for (int i = 0; i < 14 && i < popped.size(); i++)
      check("wrap_order", popped[i], (i < 2) ? 64'hB0 + 64'(i) : 64'hC0 + 64'(i - 2));
    tick();

    // Asynchronous reset mid-cycle with both FIFOs partly full
    net_ro = 1'b0;
    for (int i = 0; i < 2; i++) begin
      proc_set(1'b1, 1'b1, 2'd2, 64'h61 + 64'(2 * i));
      net_si = 1'b1;
      net_di = 64'hD0 + 64'(i);
      tick();
    end
    idle();
    net_polarity = 1'b0;
    proc_set(1'b1, 1'b0, 2'd3, '0);
    #1;
    check("pre_rst_so", 64'(net_so), 64'h1);
    #1 reset = 1'b1;
    #1;
    check("arst_so", 64'(net_so), 64'h0);
    check("arst_ri", 64'(net_ri), 64'h1);
    check("arst_inj_status", d_out, 64'h0);
    addr = 2'd1;
    #1;
    check("arst_ej_status", d_out, 64'h0);
    idle();
    tick();
    reset = 1'b0;
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      nicEn        = ($urandom_range(0, 9) < 7);
      nicWrEn      = $urandom_range(0, 1);
      addr         = 2'($urandom_range(0, 3));
      d_in         = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) d_in[0] = 1'b1;
      net_ro       = $urandom_range(0, 1);
      net_polarity = $urandom_range(0, 1);
      net_si       = $urandom_range(0, 1);
      net_di       = {$urandom, $urandom};
      tick();
    end
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
